// File: rtl/branch_unit_ras.sv
// Branch resolution unit with a circular return-address stack.
// A taken branch, jump, call or return produces a one-cycle redirect pulse
// and then a one-cycle shadow that squashes the wrong-path instruction.
module branch_unit_ras #(
  parameter int PC_W      = 8,
  parameter int RA_W      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [2:0]                   opcode,
  input  logic [3:0]                   fcode,
  input  logic [PC_W-1:0]              branch_addr,
  input  logic [PC_W-1:0]              PC,
  input  logic                         carryFlag,
  input  logic                         zeroFlag,
  input  logic                         overflowFlag,
  input  logic                         signFlag,
  input  logic                         clr_err,
  output logic [PC_W-1:0]              branch_PC,
  output logic                         PC_select,
  output logic [RA_W-1:0]              ra,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, SHADOW} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    stack_q [RAS_DEPTH];
  logic [PC_W-1:0]    stack_d [RAS_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_W-1:0]    branch_pc_q, branch_pc_d;
  logic               pc_select_q, pc_select_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic               accept;
  logic               is_branch;
  logic               is_jump;
  logic               cond_taken;
  logic               is_call;
  logic               is_ret;
  logic               stack_empty;
  logic               stack_full;
  logic [PTR_W-1:0]   top_ptr;
  logic [PC_W-1:0]    top_entry;

  // Decode the instruction and evaluate the conditional-branch predicate.
  always_comb begin
    accept      = valid_in && (state_q == IDLE);
    is_branch   = (opcode == 3'b011);
    is_jump     = (opcode == 3'b100);
    cond_taken  = 1'b0;
    case (fcode)
      4'd0:    cond_taken = 1'b1;
      4'd1:    cond_taken = zeroFlag;
      4'd2:    cond_taken = !zeroFlag;
      4'd3:    cond_taken = carryFlag;
      4'd4:    cond_taken = !carryFlag;
      4'd5:    cond_taken = signFlag;
      4'd6:    cond_taken = !signFlag;
      4'd7:    cond_taken = overflowFlag;
      4'd8:    cond_taken = !overflowFlag;
      default: cond_taken = 1'b0;
    endcase
    is_call     = accept && is_branch && (fcode == 4'd9);
    is_ret      = accept && is_branch && (fcode == 4'd10);
    stack_empty = (count_q == '0);
    stack_full  = (count_q == CNT_W'(RAS_DEPTH));
    top_ptr     = wr_ptr_q - PTR_W'(1);
    top_entry   = stack_q[top_ptr];
  end

  // Compute redirect, stack update, sticky errors and shadow sequencing.
  always_comb begin
    state_d     = IDLE;
    stack_d     = stack_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    branch_pc_d = '0;
    pc_select_d = 1'b0;
    ovf_d       = ovf_q && !clr_err;
    unf_d       = unf_q && !clr_err;

    if (accept) begin
      if (is_jump || (is_branch && cond_taken)) begin
        pc_select_d = 1'b1;
        branch_pc_d = branch_addr;
      end else if (is_call) begin
        pc_select_d       = 1'b1;
        branch_pc_d       = branch_addr;
        stack_d[wr_ptr_q] = PC;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        if (stack_full) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else if (is_ret) begin
        if (stack_empty) begin
          unf_d = 1'b1;
        end else begin
          pc_select_d = 1'b1;
          branch_pc_d = top_entry;
          wr_ptr_d    = top_ptr;
          count_d     = count_q - CNT_W'(1);
        end
      end
    end

    if ((state_q == IDLE) && pc_select_d) begin
      state_d = SHADOW;
    end
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      branch_pc_q <= '0;
      pc_select_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      branch_pc_q <= branch_pc_d;
      pc_select_q <= pc_select_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Stack storage needs no reset; entries are hidden while the count is zero.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign branch_PC = branch_pc_q;
  assign PC_select = pc_select_q;
  assign ra        = stack_empty ? '0 : RA_W'(top_entry);
  assign ras_count = count_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule
